fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the fetch address after reset.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 redirect_valid  input  1  SHALL signal a taken jump, branch or JALR from execute.
REQ-006 redirect_pc  input  XLEN  SHALL be the redirect target address.
REQ-007 imem_req_valid  output  1  SHALL signal an instruction-memory request.
REQ-008 imem_req_ready  input  1  SHALL signal that memory accepts the request.
REQ-009 imem_req_addr  output  XLEN  SHALL carry the request address.
REQ-010 imem_rsp_valid  input  1  SHALL signal returned instruction data.
REQ-011 imem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-012 inst_valid  output  1  SHALL signal a buffered instruction for decode.
REQ-013 inst_ready  input  1  SHALL signal that decode accepts the instruction.
REQ-014 inst_data  output  32  SHALL carry the buffered instruction.
REQ-015 inst_pc  output  XLEN  SHALL carry the address of inst_data.
REQ-016 inst_next_pc  output  XLEN  SHALL equal inst_pc + 4, modulo 2^XLEN.
REQ-017 fetch_count  output  32  SHALL count instructions delivered to decode.

Function
REQ-018 The FSM SHALL have exactly three states: REQ, WAIT and HOLD.
REQ-019 At most one memory request SHALL be outstanding at any time.
REQ-020 REQ: imem_req_valid = 1 and imem_req_addr = fetch_pc; a handshake (valid and ready high) SHALL move the FSM to WAIT.
REQ-021 imem_req_valid and imem_req_addr SHALL depend on registered state only, never combinationally on redirect_valid; they SHALL stay stable until the handshake.
REQ-022 WAIT: imem_rsp_valid with drop = 0 SHALL capture imem_rsp_data and the request address into the buffer and move the FSM to HOLD.
REQ-023 WAIT: imem_rsp_valid with drop = 1 SHALL discard the data, clear drop and move the FSM to REQ.
REQ-024 HOLD: inst_valid = 1; an inst_ready handshake SHALL set fetch_pc = inst_pc + 4, increment fetch_count and move the FSM to REQ.
REQ-025 inst_valid SHALL be 0 in the REQ and WAIT states.
REQ-026 A redirect SHALL load fetch_pc with redirect_pc with bits [1:0] cleared; the cleared value is the aligned target.
REQ-027 Redirect in REQ without a handshake: fetch_pc SHALL take the aligned target and the FSM SHALL stay in REQ.
REQ-028 Redirect in REQ in the same cycle as a handshake: the FSM SHALL move to WAIT with drop = 1.
REQ-029 Redirect in WAIT, including the cycle of the response: drop SHALL be set, or the response discarded if it arrives that cycle, and fetch_pc SHALL take the aligned target.
REQ-030 Redirect in HOLD: the buffer SHALL be invalidated (inst_valid = 0 next cycle) and the FSM SHALL move to REQ.
REQ-031 Redirect in HOLD together with inst_ready: the instruction counts as delivered (fetch_count increments), but fetch_pc SHALL take the redirect target, not inst_pc + 4.
REQ-032 Back-to-back redirects SHALL be honoured; the latest redirect wins.
REQ-033 fetch_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 fetch_pc SHALL wrap modulo 2^XLEN.
REQ-035 With single-cycle memory, throughput SHALL be one instruction per 3 cycles (REQ -> WAIT -> HOLD).

Reset
REQ-036 On reset: state = REQ, fetch_pc = RESET_PC, drop = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, fetch_count = 0.
REQ-037 imem_req_valid SHALL be 1 in the first cycle after reset deasserts.
REQ-038 Reset asserted mid-operation SHALL override all other inputs.
REQ-039 A response arriving in the cycle after reset SHALL be ignored.

Verification
REQ-040 Reset release, memory always ready, 1-cycle response, inst_ready = 1 -> addresses 0x0, 0x4, 0x8 issued every 3 cycles; fetch_count = 3 after the third delivery.
REQ-041 inst_ready = 0 for 5 cycles in HOLD -> inst_data and inst_pc stable, imem_req_valid = 0, fetch_count unchanged.
REQ-042 redirect_pc = 0x103 while in WAIT -> response discarded, inst_valid stays 0, next request address = 0x100.
REQ-043 Redirect to 0x200 with inst_ready in HOLD at inst_pc = 0x40 -> fetch_count increments, next request address = 0x200, not 0x44.
REQ-044 imem_req_ready held 0 for 4 cycles, redirect to 0x80 in the second cycle -> imem_req_addr changes to 0x80 from the next cycle; no request to the old address completes.
REQ-045 Reset asserted in HOLD with inst_valid = 1 -> next cycle inst_valid = 0, imem_req_addr = RESET_PC, fetch_count = 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a one-entry
// instruction buffer toward decode, and redirect handling with stale-response drop.
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_next_pc,
  output logic [31:0]     fetch_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] redirect_target;
  logic            drop_q, drop_d;
  logic            capture;
  logic            deliver;

  // Request address is the fetch PC register itself, so it never sees redirect_valid combinationally.
  assign imem_req_addr   = fetch_pc_q;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  // Next-state, fetch PC and drop-flag logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    capture    = 1'b0;
    deliver    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
        if (redirect_valid) fetch_pc_d = redirect_target;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
        if (redirect_valid) fetch_pc_d = redirect_target;
      end
      S_HOLD: begin
        if (inst_ready) begin
          deliver    = 1'b1;
          state_d    = S_REQ;
          fetch_pc_d = inst_next_pc;
        end
        // A redirect both flushes the buffer and overrides the sequential PC.
        if (redirect_valid) begin
          state_d    = S_REQ;
          fetch_pc_d = redirect_target;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State, buffer and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_REQ;
      fetch_pc_q     <= RESET_PC;
      drop_q         <= 1'b0;
      imem_req_valid <= 1'b1;
      inst_valid     <= 1'b0;
      inst_data      <= '0;
      inst_pc        <= '0;
      inst_next_pc   <= XLEN'(4);
      fetch_count    <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      drop_q         <= drop_d;
      imem_req_valid <= (state_d == S_REQ);
      inst_valid     <= (state_d == S_HOLD);
      if (capture) begin
        inst_data    <= imem_rsp_data;
        inst_pc      <= fetch_pc_q;
        inst_next_pc <= fetch_pc_q + XLEN'(4);
      end
      if (deliver) fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_fetch_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_next_pc;
  logic [31:0]     fetch_count;

  fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_next_pc   (inst_next_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rr;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_data;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic rr, logic rv, logic [31:0] rdata,
                              logic ir, logic e_rqv, logic [31:0] e_addr, logic e_iv,
                              logic [31:0] e_ipc, logic [31:0] e_data, logic [31:0] e_cnt);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.rr = rr; v.rv = rv; v.rdata = rdata; v.ir = ir;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
    v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] rpc, input logic rr, input logic rv,
                       input logic [31:0] rdata, input logic ir);
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rr;
    imem_rsp_valid = rv;
    imem_rsp_data  = rdata;
    inst_ready     = ir;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Transaction-level reference: pending request flag, stale flag, buffer queue.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_out;
  bit          m_stale;
  logic [63:0] m_buf[$];

  task automatic model_init();
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_buf.delete();
  endtask

  task automatic model_step(input logic rst, input logic rd, input logic [31:0] rpc,
                            input logic rr, input logic rv, input logic [31:0] rdata,
                            input logic ir);
    logic [31:0] tgt;
    tgt = rpc & ~32'h3;
    if (rst) begin
      model_init();
    end else if (m_buf.size() != 0) begin
      if (ir) begin
        m_cnt = m_cnt + 32'd1;
        m_pc  = rd ? tgt : m_buf[0][63:32] + 32'd4;
        void'(m_buf.pop_front());
      end else if (rd) begin
        m_buf.delete();
        m_pc = tgt;
      end
    end else if (m_out) begin
      if (rv) begin
        if (!(m_stale || rd)) m_buf.push_back({m_pc, rdata});
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else if (rd) begin
        m_stale = 1'b1;
      end
      if (rd) m_pc = tgt;
    end else begin
      if (rr) begin
        m_out   = 1'b1;
        m_stale = rd;
      end
      if (rd) m_pc = tgt;
    end
  endtask

  task automatic model_compare();
    logic e_rqv;
    e_rqv = !m_out && (m_buf.size() == 0);
    chk("rnd_req_valid", 32'(imem_req_valid), 32'(e_rqv));
    if (e_rqv) chk("rnd_req_addr", imem_req_addr, m_pc);
    chk("rnd_inst_valid", 32'(inst_valid), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      chk("rnd_inst_pc", inst_pc, m_buf[0][63:32]);
      chk("rnd_inst_data", inst_data, m_buf[0][31:0]);
      chk("rnd_inst_next_pc", inst_next_pc, m_buf[0][63:32] + 32'd4);
    end
    chk("rnd_fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    logic        r_rst, r_rd, r_rr, r_rv, r_ir;
    logic [31:0] r_rpc, r_data;

    tbl[0]  = mk(0, 0,      1, 0, 0,            1, 1, 32'h0,   0, 0,       0,            0);
    tbl[1]  = mk(0, 0,      1, 1, 32'h00000013, 1, 0, 0,       0, 0,       0,            0);
    tbl[2]  = mk(0, 0,      1, 0, 0,            1, 0, 0,       1, 32'h0,   32'h00000013, 0);
    tbl[3]  = mk(0, 0,      1, 0, 0,            1, 1, 32'h4,   0, 0,       0,            1);
    tbl[4]  = mk(0, 0,      1, 1, 32'h00100093, 1, 0, 0,       0, 0,       0,            1);
    tbl[5]  = mk(0, 0,      1, 0, 0,            1, 0, 0,       1, 32'h4,   32'h00100093, 1);
    tbl[6]  = mk(0, 0,      1, 0, 0,            1, 1, 32'h8,   0, 0,       0,            2);
    tbl[7]  = mk(0, 0,      1, 1, 32'h00200113, 1, 0, 0,       0, 0,       0,            2);
    tbl[8]  = mk(0, 0,      1, 0, 0,            1, 0, 0,       1, 32'h8,   32'h00200113, 2);
    tbl[9]  = mk(0, 0,      1, 0, 0,            1, 1, 32'hC,   0, 0,       0,            3);
    tbl[10] = mk(0, 0,      1, 1, 32'h00300193, 0, 0, 0,       0, 0,       0,            3);
    for (int i = 11; i <= 15; i++)
      tbl[i] = mk(0, 0,     1, 0, 0,            0, 0, 0,       1, 32'hC,   32'h00300193, 3);
    tbl[16] = mk(0, 0,      1, 0, 0,            1, 0, 0,       1, 32'hC,   32'h00300193, 3);
    tbl[17] = mk(0, 0,      1, 0, 0,            1, 1, 32'h10,  0, 0,       0,            4);
    tbl[18] = mk(1, 32'h103, 1, 0, 0,           1, 0, 0,       0, 0,       0,            4);
    tbl[19] = mk(0, 0,      1, 1, 32'hDEADBEEF, 1, 0, 0,       0, 0,       0,            4);
    tbl[20] = mk(0, 0,      0, 0, 0,            1, 1, 32'h100, 0, 0,       0,            4);
    tbl[21] = mk(0, 0,      1, 0, 0,            1, 1, 32'h100, 0, 0,       0,            4);
    tbl[22] = mk(0, 0,      1, 1, 32'h00600313, 1, 0, 0,       0, 0,       0,            4);
    tbl[23] = mk(0, 0,      1, 0, 0,            1, 0, 0,       1, 32'h100, 32'h00600313, 4);
    tbl[24] = mk(1, 32'h40, 0, 0, 0,            1, 1, 32'h104, 0, 0,       0,            5);
    tbl[25] = mk(0, 0,      1, 0, 0,            1, 1, 32'h40,  0, 0,       0,            5);
    tbl[26] = mk(0, 0,      1, 1, 32'h00700393, 1, 0, 0,       0, 0,       0,            5);
    tbl[27] = mk(1, 32'h200, 1, 0, 0,           1, 0, 0,       1, 32'h40,  32'h00700393, 5);
    tbl[28] = mk(0, 0,      0, 0, 0,            1, 1, 32'h200, 0, 0,       0,            6);
    tbl[29] = mk(0, 0,      0, 0, 0,            1, 1, 32'h200, 0, 0,       0,            6);

    do_reset();
    chk("reset_inst_data", inst_data, 32'h0);
    chk("reset_inst_pc", inst_pc, 32'h0);

    // Directed vector table
    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].rd, tbl[i].rpc, tbl[i].rr, tbl[i].rv, tbl[i].rdata, tbl[i].ir);
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rqv));
      if (tbl[i].e_rqv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
        chk($sformatf("vec%0d_inst_data", i), inst_data, tbl[i].e_data);
        chk($sformatf("vec%0d_inst_next_pc", i), inst_next_pc, tbl[i].e_ipc + 32'd4);
      end
      chk($sformatf("vec%0d_fetch_count", i), fetch_count, tbl[i].e_cnt);
      tick();
    end

    // Stalled request redirected mid-stall: address switches, old one never handshakes
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 32'h80, 0, 0, 0, 0);
    chk("stall_addr_before", imem_req_addr, 32'h200);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("stall_valid_after", 32'(imem_req_valid), 32'h1);
    chk("stall_addr_after", imem_req_addr, 32'h80);
    tick();
    chk("stall_addr_hold", imem_req_addr, 32'h80);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    chk("stall_addr_hs", imem_req_addr, 32'h80);
    tick();
    chk("wait_no_req", 32'(imem_req_valid), 32'h0);
    drive(0, 0, 0, 1, 32'hCAFE0001, 0);
    tick();
    chk("stall_inst_pc", inst_pc, 32'h80);
    chk("stall_inst_valid", 32'(inst_valid), 32'h1);

    // Reset in HOLD overrides handshakes; response in first cycle after reset is ignored
    reset = 1'b1;
    drive(1, 32'h300, 1, 1, 32'h12345678, 1);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 1, 32'h87654321, 0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    tick();
    chk("rsp_after_rst_ignored", 32'(inst_valid), 32'h0);
    chk("rsp_after_rst_req", 32'(imem_req_valid), 32'h1);

    // PC wrap: unaligned redirect near top of address space, then sequential next is 0
    drive(1, 32'hFFFFFFFF, 0, 0, 0, 0);
    tick();
    chk("wrap_aligned_addr", imem_req_addr, 32'hFFFFFFFC);
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 32'h0000006F, 0);
    tick();
    chk("wrap_inst_pc", inst_pc, 32'hFFFFFFFC);
    chk("wrap_inst_next_pc", inst_next_pc, 32'h0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    chk("wrap_fetch_count", fetch_count, 32'h1);

    // Random traffic against the reference model
    do_reset();
    model_init();
    for (int n = 0; n < 3000; n++) begin
      r_rst  = ($urandom_range(0, 299) == 0);
      r_rd   = ($urandom_range(0, 7) == 0);
      r_rpc  = $urandom();
      r_rr   = $urandom_range(0, 1) == 1;
      r_rv   = $urandom_range(0, 1) == 1;
      r_data = $urandom();
      r_ir   = $urandom_range(0, 2) != 0;
      reset  = r_rst;
      drive(r_rd, r_rpc, r_rr, r_rv, r_data, r_ir);
      model_compare();
      tick();
      model_step(r_rst, r_rd, r_rpc, r_rr, r_rv, r_data, r_ir);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
